// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and helpers for the clearable byte-enable RAM
package ram_pkg;

    typedef enum logic {
        RAM_CLEAR = 1'b0,
        RAM_IDLE  = 1'b1
    } ram_state_t;

    // Upper bound for the lane-merge helper; wider instances are rejected at elaboration.
    localparam int MAX_DATA_WIDTH = 1024;
    localparam int MAX_BYTES      = 1024;

    function automatic int calc_num_bytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    function automatic int calc_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic logic [MAX_DATA_WIDTH-1:0] merge_lanes(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BYTES-1:0]      byte_en,
        input int                        byte_width
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MAX_DATA_WIDTH; b++) begin
            if (byte_en[b / byte_width]) begin
                merged[b] = new_word[b];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_clear_sequencer.sv
// rtl/ram_clear_sequencer.sv - sweeps every word address once after reset or clear_request
module ram_clear_sequencer
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_request,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    // One spare bit keeps the terminal compare from aliasing with address 0.
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

    ram_state_t            state;
    ram_state_t            state_next;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RAM_CLEAR;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            RAM_CLEAR: begin
                if (count == LAST_ADDR) begin
                    state_next = RAM_IDLE;
                    count_next = '0;
                end else begin
                    count_next = count + ONE;
                end
            end
            RAM_IDLE: begin
                if (clear_request) begin
                    state_next = RAM_CLEAR;
                    count_next = '0;
                end
            end
            default: state_next = RAM_CLEAR;
        endcase
    end

    always_comb begin
        busy     = (state == RAM_CLEAR);
        clr_we   = (state == RAM_CLEAR);
        clr_addr = count[ADDR_WIDTH-1:0];
    end

endmodule

// File: rtl/clearable_byte_ram.sv
// rtl/clearable_byte_ram.sv - simple dual-port byte-enable RAM with write-first
// forwarding, 1/2-cycle read latency and a hardware clear sweep
module clearable_byte_ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int BYTE_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int NUM_BYTES   = calc_num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_request,
    output logic                  busy,
    input  logic                  wr_enable,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_BYTES-1:0]  wr_byte_en,
    input  logic                  rd_enable,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int DEPTH = calc_depth(ADDR_WIDTH);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("DATA_WIDTH exceeds ram_pkg::MAX_DATA_WIDTH");
    end

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    ram_clear_sequencer #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_clear_sequencer (
        .clock         (clock),
        .reset         (reset),
        .clear_request (clear_request),
        .busy          (busy),
        .clr_we        (clr_we),
        .clr_addr      (clr_addr)
    );

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  user_we;
    logic                  rd_accept;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_data;
    logic [NUM_BYTES-1:0]  arr_be;

    always_comb begin
        user_we   = wr_enable & ~busy;
        rd_accept = rd_enable & ~busy;
        arr_we    = clr_we | user_we;
        arr_addr  = clr_we ? clr_addr : wr_addr;
        arr_data  = clr_we ? CLEAR_VALUE : wr_data;
        arr_be    = clr_we ? {NUM_BYTES{1'b1}} : wr_byte_en;
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (arr_we && arr_be[i]) begin
                mem[arr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= arr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Write-first: a same-address write in the read cycle overrides only its enabled lanes.
    logic [NUM_BYTES-1:0]      fwd_be;
    logic [MAX_DATA_WIDTH-1:0] merged_wide;
    logic [DATA_WIDTH-1:0]     read_word;

    always_comb begin
        fwd_be      = (user_we && (wr_addr == rd_addr)) ? wr_byte_en : '0;
        merged_wide = merge_lanes(MAX_DATA_WIDTH'(mem[rd_addr]), MAX_DATA_WIDTH'(wr_data),
                                  MAX_BYTES'(fwd_be), BYTE_WIDTH);
        read_word   = merged_wide[DATA_WIDTH-1:0];
    end

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_accept;
            if (rd_accept) begin
                s1_data <= read_word;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_valid;
        logic [DATA_WIDTH-1:0] s2_data;

        always_ff @(posedge clock) begin
            if (reset) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign rd_valid = s2_valid;
        assign rd_data  = s2_data;
    end else begin : g_lat1
        assign rd_valid = s1_valid;
        assign rd_data  = s1_data;
    end

endmodule

// File: tb/tb_clearable_byte_ram.sv
// tb/tb_clearable_byte_ram.sv - scoreboard bench for clearable_byte_ram at both read latencies
module tb_clearable_byte_ram;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] CLR = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear_request = 1'b0;
    logic          wr_enable = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    wr_byte_en = '0;
    logic          rd_enable = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic          busy1, busy2, rd_valid1, rd_valid2;
    logic [DW-1:0] rd_data1, rd_data2;

    always #5 clk = ~clk;

    clearable_byte_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
                         .READ_LATENCY(1), .CLEAR_VALUE(CLR)) u_dut1 (
        .clock(clk), .reset(reset), .clear_request(clear_request), .busy(busy1),
        .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
        .rd_enable(rd_enable), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
    );

    clearable_byte_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
                         .READ_LATENCY(2), .CLEAR_VALUE(CLR)) u_dut2 (
        .clock(clk), .reset(reset), .clear_request(clear_request), .busy(busy2),
        .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
        .rd_enable(rd_enable), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q1[$];
    exp_t          q2[$];
    logic [DW-1:0] model [DEPTH];
    int            cyc = 0;
    int            compared = 0;
    int            mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [3:0] be);
        logic [DW-1:0] r;
        r = old_w;
        if (be[0]) r[7:0]   = new_w[7:0];
        if (be[1]) r[15:8]  = new_w[15:8];
        if (be[2]) r[23:16] = new_w[23:16];
        if (be[3]) r[31:24] = new_w[31:24];
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rd_valid1 === 1'b1) begin
            compared++;
            if (q1.size() == 0) begin
                mismatched++;
                $display("FAIL lat1_unexpected_valid: got rd_data=%h at cycle %0d, required no rd_valid", rd_data1, cyc);
            end else begin
                e = q1.pop_front();
                if (rd_data1 !== e.data || cyc !== e.due) begin
                    mismatched++;
                    $display("FAIL lat1_read: got %h at cycle %0d, required %h at cycle %0d", rd_data1, cyc, e.data, e.due);
                end
            end
        end else if (q1.size() > 0 && q1[0].due < cyc) begin
            e = q1.pop_front();
            compared++;
            mismatched++;
            $display("FAIL lat1_missing_valid: got none at cycle %0d, required %h", e.due, e.data);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rd_valid2 === 1'b1) begin
            compared++;
            if (q2.size() == 0) begin
                mismatched++;
                $display("FAIL lat2_unexpected_valid: got rd_data=%h at cycle %0d, required no rd_valid", rd_data2, cyc);
            end else begin
                e = q2.pop_front();
                if (rd_data2 !== e.data || cyc !== e.due) begin
                    mismatched++;
                    $display("FAIL lat2_read: got %h at cycle %0d, required %h at cycle %0d", rd_data2, cyc, e.data, e.due);
                end
            end
        end else if (q2.size() > 0 && q2[0].due < cyc) begin
            e = q2.pop_front();
            compared++;
            mismatched++;
            $display("FAIL lat2_missing_valid: got none at cycle %0d, required %h", e.due, e.data);
        end
    end

    // Drives one cycle of stimulus; when idle, predicts read results and updates the model.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [3:0] be, input logic re, input logic [AW-1:0] ra,
                        input logic clr, input bit busy_now);
        exp_t e;
        wr_enable = we; wr_addr = wa; wr_data = wd; wr_byte_en = be;
        rd_enable = re; rd_addr = ra; clear_request = clr;
        if (!busy_now && !reset) begin
            if (re) begin
                e.data = model[ra];
                if (we && wa == ra) e.data = lane_merge(e.data, wd, be);
                e.due = cyc + 1;
                q1.push_back(e);
                e.due = cyc + 2;
                q2.push_back(e);
            end
            if (we) model[wa] = lane_merge(model[wa], wd, be);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, '0, 0, 0);
    endtask

    task automatic count_busy(input string name);
        int n1, n2;
        n1 = 0;
        n2 = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy1 === 1'b1) n1++;
            if (busy2 === 1'b1) n2++;
            if (k < 16) step(1, AW'(k), $urandom, 4'hF, 1, AW'(k), 0, 1);
            else        step(0, '0, '0, '0, 0, '0, 0, 1);
        end
        compared++;
        if (n1 !== 16 || n2 !== 16) begin
            mismatched++;
            $display("FAIL %s_busy_cycles: got %0d/%0d, required 16/16", name, n1, n2);
        end
        compared++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_busy_end: got %b/%b, required 0/0", name, busy1, busy2);
        end
        for (int a = 0; a < DEPTH; a++) model[a] = CLR;
    endtask

    task automatic fill_all(input logic [DW-1:0] v);
        for (int a = 0; a < DEPTH; a++) step(1, AW'(a), v, 4'hF, 0, '0, 0, 0);
        idle(3);
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) step(0, '0, '0, '0, 1, AW'(a), 0, 0);
        idle(3);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        compared++;
        if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0 || rd_data1 !== '0 || rd_data2 !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got valid %b/%b data %h/%h, required 0/0 0/0",
                     rd_valid1, rd_valid2, rd_data1, rd_data2);
        end
        compared++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_busy: got %b/%b, required 1/1", busy1, busy2);
        end
        reset = 1'b0;
        count_busy("reset");
    endtask

    task automatic test_clear_readback();
        read_all();
    endtask

    task automatic test_byte_enables();
        step(1, 4'd5, 32'h1122_3344, 4'hF, 0, '0, 0, 0);
        step(1, 4'd5, 32'hAABB_CCDD, 4'b0101, 0, '0, 0, 0);
        step(1, 4'd5, 32'h5555_5555, 4'b0000, 0, '0, 0, 0);
        step(0, '0, '0, '0, 1, 4'd5, 0, 0);
        idle(3);
        compared++;
        if (model[5] !== 32'h11BB_33DD) begin
            mismatched++;
            $display("FAIL byte_en_model: got %h, required 11bb33dd", model[5]);
        end
    endtask

    task automatic test_same_cycle_raw();
        step(1, 4'd7, 32'hDEAD_BEEF, 4'b1100, 1, 4'd7, 0, 0);
        step(1, 4'd3, 32'h1234_5678, 4'hF, 1, 4'd5, 0, 0);
        step(1, 4'd9, 32'hCAFE_F00D, 4'hF, 0, '0, 0, 0);
        step(0, '0, '0, '0, 1, 4'd9, 0, 0);
        step(0, '0, '0, '0, 1, 4'd7, 0, 0);
        idle(3);
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 10; a++) step(1, AW'(a), 32'h1000_0000 + a * 32'h0101_0101, 4'hF, 0, '0, 0, 0);
        for (int a = 0; a < 10; a++) step(0, '0, '0, '0, 1, AW'(a), 0, 0);
        idle(4);
        compared++;
        if (rd_data1 !== model[9] || rd_data2 !== model[9] || rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin
            mismatched++;
            $display("FAIL rd_data_hold: got %h/%h valid %b/%b, required %h idle",
                     rd_data1, rd_data2, rd_valid1, rd_valid2, model[9]);
        end
    endtask

    task automatic test_clear_request();
        fill_all(32'hFFFF_FFFF);
        step(0, '0, '0, '0, 1, 4'd2, 1, 0);
        count_busy("clear");
        read_all();
    endtask

    task automatic test_reset_mid_sweep();
        fill_all(32'hFFFF_FFFF);
        step(0, '0, '0, '0, 0, '0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, '0, '0, '0, 0, '0, 0, 1);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) step(0, '0, '0, '0, 0, '0, 0, 1);
        reset = 1'b0;
        count_busy("mid_reset");
        read_all();
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) model[a] = CLR;
        @(negedge clk);
        test_reset();
        test_clear_readback();
        test_byte_enables();
        test_same_cycle_raw();
        test_back_to_back();
        test_clear_request();
        test_reset_mid_sweep();
        for (int i = 0; i < 20 && (q1.size() > 0 || q2.size() > 0); i++) @(negedge clk);
        compared++;
        if (q1.size() != 0 || q2.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d/%0d outstanding reads, required 0/0", q1.size(), q2.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
